// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared encodings for the serial magnitude compare sequencer.
// Build option: SERIAL_CMP_EARLY_EXIT_EN (consumed by the top module).
package serial_mag_compare_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DEC_UNDEC = 2'd0,
      DEC_LT    = 2'd1,
      DEC_GT    = 2'd2
   } dec_t;

   // Digit counter must hold N-1; keep at least one bit for the N=1 case.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_if.sv
// Request/result bundle between a requester and the serial compare sequencer.
interface serial_mag_compare_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             a_lt_b;
   logic             a_eq_b;
   logic             a_gt_b;

   modport master (
      output start, a, b,
      input  busy, done, a_lt_b, a_eq_b, a_gt_b
   );

   modport slave (
      input  start, a, b,
      output busy, done, a_lt_b, a_eq_b, a_gt_b
   );
endinterface

// File: rtl/serial_mag_compare_ctrl_comparator.sv
// Existing 2-bit unsigned magnitude comparator shared with the sequencer.
module comparator (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       lt,
   output logic       eq,
   output logic       gt
);
   assign lt = (x < y);
   assign eq = (x == y);
   assign gt = (x > y);
endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial WIDTH-bit compare, one 2-bit digit per clock, MSB digit first.
// Build option: SERIAL_CMP_EARLY_EXIT_EN ends RUN on the first unequal digit.
module serial_mag_compare_ctrl
   import serial_mag_compare_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_mag_compare_ctrl_if.slave bus
);
   localparam int N  = WIDTH / 2;
   localparam int CW = cnt_width(N);

   state_t           state_reg, state_next;
   dec_t             dec_reg, dec_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
   logic [CW-1:0]    cnt_reg;
   logic             lt_reg, eq_reg, gt_reg;
   logic             dig_lt, dig_eq, dig_gt;
   logic             last_digit;

   comparator u_cmp (
      .x  (a_sh_reg[WIDTH-1 -: 2]),
      .y  (b_sh_reg[WIDTH-1 -: 2]),
      .lt (dig_lt),
      .eq (dig_eq),
      .gt (dig_gt)
   );

   // Sticky decision: only the first unequal digit is ever recorded.
   always_comb begin
      dec_next = dec_reg;
      if (dec_reg == DEC_UNDEC && !dig_eq) begin
         if (dig_lt)
            dec_next = DEC_LT;
         else if (dig_gt)
            dec_next = DEC_GT;
      end
   end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign last_digit = (cnt_reg == '0) || (dec_next != DEC_UNDEC);
`else
   assign last_digit = (cnt_reg == '0);
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.start) state_next = ST_RUN;
         ST_RUN:  if (last_digit) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         dec_reg   <= DEC_UNDEC;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         cnt_reg   <= '0;
         lt_reg    <= 1'b0;
         eq_reg    <= 1'b0;
         gt_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  a_sh_reg <= bus.a;
                  b_sh_reg <= bus.b;
                  cnt_reg  <= CW'(N - 1);
                  dec_reg  <= DEC_UNDEC;
                  lt_reg   <= 1'b0;
                  eq_reg   <= 1'b0;
                  gt_reg   <= 1'b0;
               end
            end
            ST_RUN: begin
               a_sh_reg <= a_sh_reg << 2;
               b_sh_reg <= b_sh_reg << 2;
               cnt_reg  <= cnt_reg - CW'(1);
               dec_reg  <= dec_next;
               // Flags land together with the move into DONE.
               if (last_digit) begin
                  lt_reg <= (dec_next == DEC_LT);
                  gt_reg <= (dec_next == DEC_GT);
                  eq_reg <= (dec_next == DEC_UNDEC);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state_reg == ST_RUN);
   assign bus.done   = (state_reg == ST_DONE);
   assign bus.a_lt_b = lt_reg;
   assign bus.a_eq_b = eq_reg;
   assign bus.a_gt_b = gt_reg;

endmodule
